// File: rtl/exe_pkg.sv
// Shared definitions for the matrix CPU execution sequencer: opcode map,
// functional-unit indices, FSM state encoding and error codes.
package exe_pkg;

   localparam int OP_ADD       = 0;
   localparam int OP_SUB       = 1;
   localparam int OP_SCALE     = 2;
   localparam int OP_MULT      = 3;
   localparam int OP_TRANSPOSE = 4;
   localparam int OP_RSVD      = 5;
   localparam int OP_WRITE_MEM = 6;
   localparam int OP_STOP      = 7;

   localparam int UNIT_ADDSUB    = 0;
   localparam int UNIT_SCALE     = 1;
   localparam int UNIT_MULT      = 2;
   localparam int UNIT_TRANSPOSE = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT,
      ST_MEMWR,
      ST_HALT,
      ST_ERR
   } exe_state_e;

   typedef enum logic [1:0] {
      OPK_UNIT,
      OPK_MEMWR,
      OPK_STOP,
      OPK_RSVD
   } exe_opkind_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_RSVD    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/exe_opdecode.sv
// Combinational opcode classifier: maps an opcode to its kind, the one-hot
// functional unit it targets and the add/sub select.
module exe_opdecode
   import exe_pkg::*;
#(
   parameter int OPC_W     = 3,
   parameter int NUM_UNITS = 4
) (
   input  logic [OPC_W-1:0]     opcode,
   output exe_opkind_e          kind,
   output logic [NUM_UNITS-1:0] unit_sel,
   output logic                 is_sub
);

   int unit_idx;

   always_comb begin
      kind     = OPK_RSVD;
      unit_sel = '0;
      is_sub   = 1'b0;
      unit_idx = -1;
      case (int'(opcode))
         OP_ADD:       unit_idx = UNIT_ADDSUB;
         OP_SUB: begin
            unit_idx = UNIT_ADDSUB;
            is_sub   = 1'b1;
         end
         OP_SCALE:     unit_idx = UNIT_SCALE;
         OP_MULT:      unit_idx = UNIT_MULT;
         OP_TRANSPOSE: unit_idx = UNIT_TRANSPOSE;
         OP_WRITE_MEM: kind     = OPK_MEMWR;
         OP_STOP:      kind     = OPK_STOP;
         default:      kind     = OPK_RSVD;
      endcase
      // A unit op aimed at a unit this build does not have is reserved.
      if (unit_idx >= 0 && unit_idx < NUM_UNITS) begin
         kind = OPK_UNIT;
         for (int i = 0; i < NUM_UNITS; i++) begin
            unit_sel[i] = (i == unit_idx);
         end
      end
   end

endmodule

// File: rtl/exe_sequencer.sv
// Execution sequencer: accepts one instruction, starts its functional unit or
// memory write, waits for completion with a timeout, then retires it.
module exe_sequencer
   import exe_pkg::*;
#(
   parameter int OPC_W     = 3,
   parameter int NUM_UNITS = 4,
   parameter int TMO_CYC   = 255,
   parameter int TMO_W     = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OPC_W+1:0]     instr,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   output logic [NUM_UNITS-1:0] unit_start,
   output logic                 add_or_sub,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic                 write_to_mem,
   input  logic                 mem_ack,
   output logic                 read_from,
   output logic                 write_to_reg,
   output logic                 busy,
   output logic                 halted,
   output logic                 err,
   output logic [1:0]           err_code,
   input  logic                 err_clr,
   output logic [CNT_W-1:0]     retire_cnt,
   output logic [2:0]           state_dbg
);

   // Handshake: an instruction transfers on a rising edge where instr_valid
   // and instr_ready are both high; instr_ready is high only in IDLE, and
   // valid may be raised or dropped freely since nothing is taken without ready.

   exe_state_e           state, state_nxt;
   exe_opkind_e          dec_kind, kind_q;
   logic [NUM_UNITS-1:0] dec_sel, sel_q;
   logic                 dec_sub;
   logic [TMO_W-1:0]     tmo_cnt;
   logic                 accept, unit_hit, tmo_hit;
   logic                 cnt_clr, cnt_inc, retire_inc, code_set;
   logic [1:0]           code_val;

   exe_opdecode #(
      .OPC_W     (OPC_W),
      .NUM_UNITS (NUM_UNITS)
   ) u_opdecode (
      .opcode   (instr[OPC_W+1:2]),
      .kind     (dec_kind),
      .unit_sel (dec_sel),
      .is_sub   (dec_sub)
   );

   assign accept   = instr_valid & instr_ready;
   assign unit_hit = |(unit_done & sel_q);
   assign tmo_hit  = (tmo_cnt == TMO_W'(TMO_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      retire_inc = 1'b0;
      code_set   = 1'b0;
      code_val   = ERR_NONE;
      case (state)
         ST_IDLE: if (instr_valid) state_nxt = ST_DECODE;
         ST_DECODE: begin
            case (kind_q)
               OPK_UNIT:  state_nxt = ST_ISSUE;
               OPK_MEMWR: begin
                  state_nxt = ST_MEMWR;
                  cnt_clr   = 1'b1;
               end
               OPK_STOP:  state_nxt = ST_HALT;
               default: begin
                  state_nxt = ST_ERR;
                  code_set  = 1'b1;
                  code_val  = ERR_RSVD;
               end
            endcase
         end
         ST_ISSUE: begin
            state_nxt = ST_WAIT;
            cnt_clr   = 1'b1;
         end
         // Completion is checked before the timeout so a late done still wins.
         ST_WAIT, ST_MEMWR: begin
            if ((state == ST_WAIT) ? unit_hit : mem_ack) begin
               state_nxt  = ST_IDLE;
               retire_inc = 1'b1;
            end else if (tmo_hit) begin
               state_nxt = ST_ERR;
               code_set  = 1'b1;
               code_val  = ERR_TIMEOUT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_HALT: state_nxt = ST_HALT;
         ST_ERR: begin
            if (err_clr) begin
               state_nxt = ST_IDLE;
               code_set  = 1'b1;
               code_val  = ERR_NONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kind_q       <= OPK_UNIT;
         sel_q        <= '0;
         add_or_sub   <= 1'b0;
         read_from    <= 1'b0;
         write_to_reg <= 1'b0;
         tmo_cnt      <= '0;
         retire_cnt   <= '0;
         err_code     <= ERR_NONE;
      end else begin
         if (accept) begin
            kind_q       <= dec_kind;
            sel_q        <= dec_sel;
            add_or_sub   <= dec_sub;
            read_from    <= instr[1];
            write_to_reg <= instr[0];
         end
         if (cnt_clr)      tmo_cnt <= '0;
         else if (cnt_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
         if (retire_inc) retire_cnt <= retire_cnt + CNT_W'(1);
         if (code_set)   err_code   <= code_val;
      end
   end

   assign instr_ready  = (state == ST_IDLE);
   assign unit_start   = (state == ST_ISSUE) ? sel_q : '0;
   assign write_to_mem = (state == ST_MEMWR);
   assign busy         = (state == ST_DECODE) || (state == ST_ISSUE) ||
                         (state == ST_WAIT)   || (state == ST_MEMWR);
   assign halted       = (state == ST_HALT);
   assign err          = (state == ST_ERR);
   assign state_dbg    = state;

endmodule

// File: tb/tb_exe_sequencer.sv
// Self-checking bench for exe_sequencer: table vectors, randomized ops against
// a rule-level model, and hand sequences for reset, halt and error recovery.
module tb_exe_sequencer;

   localparam int TMO   = 12;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       instr;
   logic             instr_valid;
   logic             instr_ready;
   logic [3:0]       unit_start;
   logic             add_or_sub;
   logic [3:0]       unit_done;
   logic             write_to_mem;
   logic             mem_ack;
   logic             read_from;
   logic             write_to_reg;
   logic             busy;
   logic             halted;
   logic             err;
   logic [1:0]       err_code;
   logic             err_clr;
   logic [CNT_W-1:0] retire_cnt;
   logic [2:0]       state_dbg;

   int               n_checks = 0;
   int               n_errors = 0;
   logic [CNT_W-1:0] exp_retire = '0;

   typedef struct {
      logic [2:0] opc;
      logic       rf;
      logic       wr;
      int         resp_at;
      logic       stray;
      logic [3:0] exp_start;
      logic       exp_sub;
      logic [1:0] exp_err;
      logic       exp_retire;
   } vec_t;

   vec_t tbl[9];

   exe_sequencer #(
      .OPC_W     (3),
      .NUM_UNITS (4),
      .TMO_CYC   (TMO),
      .TMO_W     (8),
      .CNT_W     (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .unit_start   (unit_start),
      .add_or_sub   (add_or_sub),
      .unit_done    (unit_done),
      .write_to_mem (write_to_mem),
      .mem_ack      (mem_ack),
      .read_from    (read_from),
      .write_to_reg (write_to_reg),
      .busy         (busy),
      .halted       (halted),
      .err          (err),
      .err_code     (err_code),
      .err_clr      (err_clr),
      .retire_cnt   (retire_cnt),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected outcome of one instruction from the opcode map
   // and the rule that a response arriving within TMO cycles completes it.
   function automatic vec_t make_vec(input logic [2:0] opc, input logic rf, input logic wr,
                                     input int resp_at, input logic stray);
      vec_t v;
      int   unit;
      logic in_time;
      unit = -1;
      if (opc == 3'd0 || opc == 3'd1) unit = 0;
      else if (opc == 3'd2) unit = 1;
      else if (opc == 3'd3) unit = 2;
      else if (opc == 3'd4) unit = 3;
      in_time = (resp_at <= TMO);
      v.opc        = opc;
      v.rf         = rf;
      v.wr         = wr;
      v.resp_at    = resp_at;
      v.stray      = stray;
      v.exp_start  = (unit >= 0) ? 4'(1 << unit) : 4'b0000;
      v.exp_sub    = (opc == 3'd1);
      if (unit < 0 && opc != 3'd6) begin
         v.exp_err    = 2'd1;
         v.exp_retire = 1'b0;
      end else begin
         v.exp_err    = in_time ? 2'd0 : 2'd2;
         v.exp_retire = in_time;
      end
      return v;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!instr_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_accept", instr_ready, 1'b1);
   endtask

   task automatic exec(input vec_t v);
      int         j, hi, exp_hi;
      logic       fin;
      logic [3:0] stray_bit;
      wait_ready();
      instr       = {v.opc, v.rf, v.wr};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 5'($urandom_range(0, 31));
      check("decode_busy", busy, 1'b1);
      check("decode_ready_low", instr_ready, 1'b0);
      check("read_from", read_from, v.rf);
      check("write_to_reg", write_to_reg, v.wr);
      @(posedge clk);
      @(negedge clk);
      check("start_pulse", unit_start, v.exp_start);
      if (v.exp_start != 4'b0000) begin
         check("add_or_sub", add_or_sub, v.exp_sub);
         stray_bit = v.exp_start[1] ? 4'b0001 : 4'b0010;
         @(posedge clk);
         @(negedge clk);
         j   = 0;
         fin = 1'b0;
         while (!fin) begin
            j++;
            check("wait_busy", busy, 1'b1);
            check("wait_no_restart", unit_start, 4'b0000);
            if (j == v.resp_at)          unit_done = v.exp_start;
            else if (v.stray && j == 1)  unit_done = stray_bit;
            else                         unit_done = 4'b0000;
            if (j >= v.resp_at || j >= TMO) fin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            unit_done = 4'b0000;
         end
         check("add_or_sub_held", add_or_sub, v.exp_sub);
      end else if (v.opc == 3'd6) begin
         j   = 0;
         hi  = 0;
         fin = 1'b0;
         while (!fin) begin
            j++;
            if (write_to_mem) hi++;
            mem_ack = (j == v.resp_at);
            if (j >= v.resp_at || j >= TMO) fin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
         end
         exp_hi = (v.resp_at < TMO) ? v.resp_at : TMO;
         check("wmem_high_cycles", hi, exp_hi);
         check("wmem_dropped", write_to_mem, 1'b0);
      end
      check("err", err, v.exp_err != 2'd0);
      check("err_code", err_code, v.exp_err);
      check("ready_after", instr_ready, v.exp_err == 2'd0);
      exp_retire = exp_retire + CNT_W'(v.exp_retire);
      check("retire_cnt", retire_cnt, exp_retire);
      if (v.exp_err != 2'd0) begin
         err_clr = 1'b1;
         @(posedge clk);
         @(negedge clk);
         err_clr = 1'b0;
         check("err_cleared", err, 1'b0);
         check("err_code_cleared", err_code, 2'd0);
         check("ready_after_clr", instr_ready, 1'b1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr_ready"}, instr_ready, 1'b1);
      check({tag, "_unit_start"}, unit_start, 4'b0000);
      check({tag, "_add_or_sub"}, add_or_sub, 1'b0);
      check({tag, "_write_to_mem"}, write_to_mem, 1'b0);
      check({tag, "_read_from"}, read_from, 1'b0);
      check({tag, "_write_to_reg"}, write_to_reg, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_halted"}, halted, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_err_code"}, err_code, 2'd0);
      check({tag, "_retire_cnt"}, retire_cnt, '0);
   endtask

   initial begin
      reset       = 1'b1;
      instr       = '0;
      instr_valid = 1'b0;
      unit_done   = '0;
      mem_ack     = 1'b0;
      err_clr     = 1'b0;

      tbl[0] = '{3'd1, 1'b1, 1'b0, 3,       1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[1] = '{3'd3, 1'b0, 1'b1, 4,       1'b1, 4'b0100, 1'b0, 2'd0, 1'b1};
      tbl[2] = '{3'd6, 1'b1, 1'b1, 10,      1'b0, 4'b0000, 1'b0, 2'd0, 1'b1};
      tbl[3] = '{3'd5, 1'b0, 1'b0, 1,       1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
      tbl[4] = '{3'd0, 1'b0, 1'b1, 2,       1'b0, 4'b0001, 1'b0, 2'd0, 1'b1};
      tbl[5] = '{3'd2, 1'b1, 1'b0, TMO + 1, 1'b0, 4'b0010, 1'b0, 2'd2, 1'b0};
      tbl[6] = '{3'd2, 1'b0, 1'b0, TMO,     1'b1, 4'b0010, 1'b0, 2'd0, 1'b1};
      tbl[7] = '{3'd4, 1'b1, 1'b1, 1,       1'b0, 4'b1000, 1'b0, 2'd0, 1'b1};
      tbl[8] = '{3'd6, 1'b0, 1'b1, TMO + 1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         exec(tbl[i]);
      end

      for (int i = 0; i < 40; i++) begin
         exec(make_vec(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(1, TMO + 1),
                       1'($urandom_range(0, 1))));
      end

      // Asynchronous reset while a scale op sits in WAIT.
      wait_ready();
      instr       = {3'd2, 1'b1, 1'b1};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_wait_start", unit_start, 4'b0010);
      @(posedge clk);
      @(negedge clk);
      check("mid_wait_busy", busy, 1'b1);
      #1 reset = 1'b1;
      #1 check_reset_outputs("async_reset");
      @(negedge clk);
      reset      = 1'b0;
      exp_retire = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_no_start", unit_start, 4'b0000);
         check("post_reset_idle", instr_ready, 1'b1);
      end

      // stop: absorbs further instructions and ignores err_clr.
      wait_ready();
      instr       = {3'd7, 1'b0, 1'b0};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr = {3'd0, 1'b0, 1'b0};
      @(posedge clk);
      @(negedge clk);
      check("halted", halted, 1'b1);
      check("halt_busy", busy, 1'b0);
      err_clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("halt_stays", halted, 1'b1);
         check("halt_ready_low", instr_ready, 1'b0);
         check("halt_no_start", unit_start, 4'b0000);
      end
      err_clr     = 1'b0;
      instr_valid = 1'b0;
      check("halt_retire", retire_cnt, exp_retire);
      check("halt_no_err", err, 1'b0);

      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("halt_reset");
      reset = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/exe_sequencer.md
Name: exe_sequencer

Overview:
Parametrised successor to the matrix CPU's opcode decoder. Accepts one instruction at a time over a valid/ready handshake and decodes it. It issues a one-cycle start pulse to the selected functional unit, or a held write request to memory, then waits for completion before accepting the next instruction. Adds the following, none of which the previous decoder had: a done handshake, a completion timeout, an error/halt state, a clearable error and a retired-instruction counter. Sits between the instruction register and the add/sub, scale, mult and transpose units plus the memory write port.

Parameters:
OPC_W, 3, opcode width; instr width = OPC_W+2 (low 2 bits are flags).
NUM_UNITS, 4, functional units; unit_start/unit_done width.
TMO_CYC, 255, max WAIT/MEMWR cycles before a timeout error; 1..2^TMO_W-1.
TMO_W, 8, timeout counter width.
CNT_W, 16, retire counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
instr  in  OPC_W+2  [OPC_W+1:2] opcode, [1] read_from flag, [0] write_to_reg flag
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept
unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse
add_or_sub  out  1  0=add, 1=sub; valid with unit_start[0], held until next accept
unit_done  in  NUM_UNITS  per-unit completion pulse
write_to_mem  out  1  memory write request, held until mem_ack
mem_ack  in  1  memory write accepted
read_from  out  1  0=reg, 1=mem; captured flag
write_to_reg  out  1  captured flag
busy  out  1  state not IDLE/HALT/ERR
halted  out  1  stop executed
err  out  1  error latched
err_code  out  2  1=reserved opcode, 2=timeout, 0=none
err_clr  in  1  clear error, return to IDLE
retire_cnt  out  CNT_W  completed instructions, wraps

Behaviour:
- Reset is asynchronous, active-high, with clock clk. On reset: state IDLE; instr_ready=1; every other output 0; counters 0. Reset mid-operation abandons the instruction; no start or write is reissued.
- Opcode map (package): 0 add→unit0, add_or_sub=0; 1 sub→unit0, add_or_sub=1; 2 scale→unit1; 3 mult→unit2; 4 transpose→unit3; 5 reserved; 6 write_mem; 7 stop. Unmapped values ≥ NUM_UNITS are treated as reserved.
- IDLE: instr_ready=1. On instr_valid&instr_ready, register instr, read_from and write_to_reg, then go to DECODE. Flags hold until the next accept.
- DECODE (1 cycle):
  - unit op → ISSUE
  - write_mem → MEMWR
  - stop → HALT
  - reserved → ERR with code 1
- ISSUE (1 cycle): assert unit_start[k] and add_or_sub, clear the timeout counter, go to WAIT. Start latency is 2 cycles after the accept edge.
- WAIT: unit_done[k] → IDLE, retire_cnt+1. done from any other unit is ignored. Otherwise increment the counter; when it reaches TMO_CYC with no done → ERR with code 2. done in the same cycle as the timeout wins.
- MEMWR: write_to_mem=1. On mem_ack: drop it the next cycle, go to IDLE, retire_cnt+1. The same timeout rule applies; on timeout, write_to_mem drops.
- HALT: halted=1 and instr_ready=0, absorbing until reset. stop is not counted as retired. A simulation-only $display is permitted; no $stop.
- ERR: err=1, err_code held, instr_ready=0. err_clr → IDLE with err and err_code cleared. err_clr in any other state is ignored.
- instr_ready is 0 in every state except IDLE, so back-to-back instructions need at least 1 idle cycle.
- retire_cnt wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package exe_pkg holds: opcode localparams, unit index constants, state encoding (IDLE, DECODE, ISSUE, WAIT, MEMWR, HALT, ERR), and err_code constants.
- Opcode→unit/op decode is a natural combinational sub-module, exe_opdecode, reusable by the assembler/bench model. The FSM and counters stay in exe_sequencer.

Test Plan:
- sub, instr=5'b001_10, unit0 done 3 cycles after start → unit_start=4'b0001 at accept+2, add_or_sub=1, read_from=1, retire_cnt=1, instr_ready returns the cycle after done.
- mult with unit_done[1] pulsed then unit_done[2] → the stray done is ignored, the sequencer completes only on unit_done[2].
- write_mem, mem_ack held low for 10 cycles → write_to_mem high for exactly 10 cycles until ack, then 0, then IDLE.
- Opcode 5 → err=1, err_code=1, no start pulse. Then err_clr → IDLE; a following add executes normally.
- TMO_CYC=4 scale with no done → err_code=2 after 4 WAIT cycles. Repeat with done on cycle 4 → completes without error.
- stop, then valid instructions → halted=1, instr_ready stays 0. Async reset mid-WAIT → all outputs 0 immediately, instr_ready=1.
